// File: rtl/siso_loop_ctrl.sv
// siso_loop_ctrl: loopback sequencer for an external SISO shift register.
// Accepts one word over valid/ready and shifts it out LSB-first on sr_in. It then
// flushes the chain with FILL and collects the bits returning on sr_out into out_data.
// The optional compare is enabled by defining SISO_LOOP_CTRL_CHECK_EN.
// With that macro, mismatch flags a returned word that differs from the word sent.
module siso_loop_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter logic        FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sr_en,
  output logic             sr_in,
  input  logic             sr_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             mismatch
);

  localparam int unsigned     CW   = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH + DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] data_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: RUN lasts WIDTH+DEPTH edges, and DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. sr_in carries the latched bit[cnt] while cnt < WIDTH, and FILL otherwise
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    sr_en     = (state_q == RUN);
    out_valid = (state_q == DONE);
    sr_in     = FILL;
    if (state_q == RUN) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (cnt_q == CW'(i)) sr_in = word_q[i];
      end
    end
  end

  // Capture sr_out into bit[cnt-DEPTH] once the first sent bit has crossed the chain
  always_comb begin
    sh_d = sh_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cnt_q == CW'(DEPTH + i)) sh_d[i] = sr_out;
    end
  end

`ifdef SISO_LOOP_CTRL_CHECK_EN
  logic mm_q;
`endif

  // Datapath. Words are assembled in sh_q so that out_data stays stable until the next DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
      sh_q   <= '0;
      data_q <= '0;
`ifdef SISO_LOOP_CTRL_CHECK_EN
      mm_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_q <= in_data;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          sh_q  <= sh_d;
          if (cnt_q == LAST) begin
            data_q <= sh_d;
`ifdef SISO_LOOP_CTRL_CHECK_EN
            mm_q   <= (sh_d != word_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = data_q;

`ifdef SISO_LOOP_CTRL_CHECK_EN
  assign mismatch = mm_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_siso_loop_ctrl.sv
// Testbench for siso_loop_ctrl. Drives an 8x4 instance through directed and random
// traffic against a cycle-count reference model with a behavioural SISO. It also
// exercises a 1x1 instance for the minimum-size corner.
module tb_siso_loop_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam logic        F = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, sr_en, sr_in, sr_out, out_valid, busy, mismatch;
  logic [W-1:0] in_data, out_data;

  logic         in_valid1, in_ready1, sr_en1, sr_in1, sr_out1, out_valid1, busy1, mismatch1;
  logic [0:0]   in_data1, out_data1;

  siso_loop_ctrl #(.WIDTH(W), .DEPTH(D), .FILL(F)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sr_en(sr_en), .sr_in(sr_in), .sr_out(sr_out), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .mismatch(mismatch)
  );

  siso_loop_ctrl #(.WIDTH(1), .DEPTH(1), .FILL(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .sr_en(sr_en1), .sr_in(sr_in1), .sr_out(sr_out1), .out_valid(out_valid1),
    .out_data(out_data1), .busy(busy1), .mismatch(mismatch1)
  );

  // Behavioural SISO chains; stuck forces the 8x4 chain output high
  logic [D-1:0] chain = '0;
  logic         s1    = 1'b0;
  logic         stuck = 1'b0;
  always @(posedge clk) begin
    if (sr_en)  chain <= {chain[D-2:0], sr_in};
    if (sr_en1) s1    <= sr_in1;
  end
  assign sr_out  = stuck ? 1'b1 : chain[D-1];
  assign sr_out1 = s1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model. rem counts cycles left in the transfer: W+D+1 is the first RUN
  // cycle, 1 is the DONE cycle, and 0 means idle
  int unsigned rem      = 0;
  logic [W-1:0] word    = '0;
  logic [W-1:0] last_out = '0;
  logic         last_mm = 1'b0;

  task automatic step(input logic v, input logic [W-1:0] d);
    int unsigned k;
    logic        exp_in;
    if (rem == 1) begin
      last_out = stuck ? '1 : word;
`ifdef SISO_LOOP_CTRL_CHECK_EN
      last_mm = (last_out != word);
`else
      last_mm = 1'b0;
`endif
    end
    check("in_ready",  {31'd0, in_ready},  {31'd0, rem == 0});
    check("busy",      {31'd0, busy},      {31'd0, rem != 0});
    check("sr_en",     {31'd0, sr_en},     {31'd0, rem > 1});
    check("out_valid", {31'd0, out_valid}, {31'd0, rem == 1});
    exp_in = F;
    if (rem > 1) begin
      k = W + D + 1 - rem;
      if (k < W) exp_in = word[k];
    end
    check("sr_in",    {31'd0, sr_in},    {31'd0, exp_in});
    check("out_data", {24'd0, out_data}, {24'd0, last_out});
    check("mismatch", {31'd0, mismatch}, {31'd0, last_mm});
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    if (rem == 0) begin
      if (v && rst) begin
        rem  = W + D + 1;
        word = d;
      end
    end else begin
      rem--;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_sr_en",     {31'd0, sr_en},     32'd0);
    check("rst_sr_in",     {31'd0, sr_in},     {31'd0, F});
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_mismatch",  {31'd0, mismatch},  32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    rst = 1'b1;

    // Basic loopback
    step(1'b1, 8'hA5);
    repeat (13) step(1'b0, '0);

    // in_valid held through a transfer; second word taken after DONE
    step(1'b1, 8'h3C);
    repeat (14) step(1'b1, 8'hC3);
    repeat (14) step(1'b0, '0);

    // in_valid pulse during RUN is ignored
    step(1'b1, 8'h01);
    step(1'b0, '0);
    step(1'b1, 8'hFF);
    repeat (13) step(1'b0, '0);

    // Stuck-high chain output
    stuck = 1'b1;
    step(1'b1, 8'h00);
    repeat (13) step(1'b0, '0);
    stuck = 1'b0;

    // Reset at cnt=5 aborts the transfer
    step(1'b1, 8'h96);
    repeat (5) step(1'b0, '0);
    rst = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_sr_en",     {31'd0, sr_en},     32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data",  {24'd0, out_data},  32'd0);
    rem = 0; last_out = '0; last_mm = 1'b0;
    step(1'b0, '0);
    rst = 1'b1;
    step(1'b1, 8'h5A);
    repeat (13) step(1'b0, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (rem == 0) stuck = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 2) == 0), W'($urandom));
    end
    repeat (14) step(1'b0, '0);
    stuck = 1'b0;

    // WIDTH=1, DEPTH=1: two shift cycles, out_valid two cycles after accept
    in_valid1 = 1'b1; in_data1 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
    check("w1_sr_en0",  {31'd0, sr_en1},     32'd1);
    check("w1_sr_in0",  {31'd0, sr_in1},     32'd1);
    check("w1_busy",    {31'd0, busy1},      32'd1);
    @(posedge clk); @(negedge clk);
    check("w1_sr_en1",  {31'd0, sr_en1},     32'd1);
    check("w1_sr_in1",  {31'd0, sr_in1},     32'd0);
    check("w1_ov_early",{31'd0, out_valid1}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("w1_ov",      {31'd0, out_valid1}, 32'd1);
    check("w1_sr_en2",  {31'd0, sr_en1},     32'd0);
    check("w1_data",    {31'd0, out_data1},  32'd1);
    @(posedge clk); @(negedge clk);
    check("w1_idle",    {31'd0, in_ready1},  32'd1);
    check("w1_ov_end",  {31'd0, out_valid1}, 32'd0);
    check("w1_hold",    {31'd0, out_data1},  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
